// File: rtl/mac_share_pkg.sv
// Shared types and arithmetic helpers for the mac_share_seq engine.
// MAC_SHARE_SAT_EN selects saturating instead of wrapping output conversion.
package mac_share_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // Widest sum the conversion helper accepts; callers sign-extend into it.
    localparam int SUM_MAX = 128;

    function automatic int calc_s_w(input int a_w, input int b_w, input int c_w);
        return (((a_w + b_w) > c_w) ? (a_w + b_w) : c_w) + 1;
    endfunction

    function automatic logic signed [SUM_MAX-1:0] out_conv(
        input logic signed [SUM_MAX-1:0] sum,
        input int                        out_w
    );
`ifdef MAC_SHARE_SAT_EN
        logic signed [SUM_MAX-1:0] one_v;
        logic signed [SUM_MAX-1:0] hi_v;
        logic signed [SUM_MAX-1:0] lo_v;
        one_v = {{(SUM_MAX-1){1'b0}}, 1'b1};
        hi_v  = (one_v <<< (out_w - 1)) - one_v;
        lo_v  = ~hi_v;
        if (sum > hi_v) begin
            return hi_v;
        end else if (sum < lo_v) begin
            return lo_v;
        end else begin
            return sum;
        end
`else
        // Constant mask folds away; the caller keeps only the low out_w bits.
        logic [SUM_MAX-1:0] mask_v;
        mask_v = ~({SUM_MAX{1'b1}} << out_w);
        return sum & mask_v;
`endif
    endfunction

endpackage

// File: rtl/mac_share_dsp.sv
// Three-stage signed multiply-add slice: operands, product, sum. Processes
// one channel per enabled cycle and carries a valid/index tag alongside.
(* use_dsp = "yes" *)
module mac_share_dsp
    import mac_share_pkg::*;
#(
    parameter int A_W   = 27,
    parameter int B_W   = 18,
    parameter int C_W   = 48,
    parameter int S_W   = 49,
    parameter int IDX_W = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ce,
    input  logic                    in_valid,
    input  logic [IDX_W-1:0]        in_idx,
    input  logic signed [A_W-1:0]   a,
    input  logic signed [B_W-1:0]   b,
    input  logic signed [C_W-1:0]   c,
    output logic signed [S_W-1:0]   p,
    output logic                    p_valid,
    output logic [IDX_W-1:0]        p_idx
);
    localparam int M_W = A_W + B_W;

    logic signed [A_W-1:0] a_r;
    logic signed [B_W-1:0] b_r;
    logic signed [C_W-1:0] c1_r;
    logic signed [C_W-1:0] c2_r;
    logic signed [M_W-1:0] m_r;
    logic signed [S_W-1:0] p_r;
    logic                  v1_r, v2_r, v3_r;
    logic [IDX_W-1:0]      idx1_r, idx2_r, idx3_r;
    logic signed [S_W-1:0] m_ext_s;
    logic signed [S_W-1:0] c_ext_s;

    // Sign-extend product and addend to the full sum width.
    always_comb begin
        m_ext_s = S_W'(m_r);
        c_ext_s = S_W'(c2_r);
    end

    // Pipeline registers; every stage freezes while ce is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r    <= '0;
            b_r    <= '0;
            c1_r   <= '0;
            c2_r   <= '0;
            m_r    <= '0;
            p_r    <= '0;
            v1_r   <= 1'b0;
            v2_r   <= 1'b0;
            v3_r   <= 1'b0;
            idx1_r <= '0;
            idx2_r <= '0;
            idx3_r <= '0;
        end else if (ce) begin
            a_r    <= a;
            b_r    <= b;
            c1_r   <= c;
            v1_r   <= in_valid;
            idx1_r <= in_idx;
            m_r    <= a_r * b_r;
            c2_r   <= c1_r;
            v2_r   <= v1_r;
            idx2_r <= idx1_r;
            p_r    <= m_ext_s + c_ext_s;
            v3_r   <= v2_r;
            idx3_r <= idx2_r;
        end
    end

    assign p       = p_r;
    assign p_valid = v3_r;
    assign p_idx   = idx3_r;

endmodule

// File: rtl/mac_share_seq.sv
// Batch multiply-add engine: captures N_CH operand sets, sequences them through
// one shared mac_share_dsp and presents all results. MAC_SHARE_SAT_EN: saturate.
module mac_share_seq
    import mac_share_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int A_W   = 27,
    parameter int B_W   = 18,
    parameter int C_W   = 48,
    parameter int OUT_W = 48
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,
    input  logic                    ap_ce,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N_CH*A_W-1:0]     a,
    input  logic [N_CH*B_W-1:0]     b,
    input  logic [N_CH*C_W-1:0]     c,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [N_CH*OUT_W-1:0]   dout
);
    localparam int S_W   = calc_s_w(A_W, B_W, C_W);
    localparam int CNT_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [CNT_W-1:0] LAST_CH = CNT_W'(N_CH - 1);

    state_t                 state_r;
    logic [CNT_W-1:0]       ch_r;
    logic [N_CH*A_W-1:0]    a_bat_r;
    logic [N_CH*B_W-1:0]    b_bat_r;
    logic [N_CH*C_W-1:0]    c_bat_r;
    logic                   out_valid_r;
    logic [N_CH*OUT_W-1:0]  dout_r;

    logic [A_W-1:0]         a_sel_s;
    logic [B_W-1:0]         b_sel_s;
    logic [C_W-1:0]         c_sel_s;
    logic                   issue_s;
    logic signed [S_W-1:0]  p_s;
    logic                   p_valid_s;
    logic [CNT_W-1:0]       p_idx_s;
    logic [OUT_W-1:0]       conv_s;

    // Channel mux into the shared datapath and output conversion of its sum.
    always_comb begin
        a_sel_s = a_bat_r[int'(ch_r)*A_W +: A_W];
        b_sel_s = b_bat_r[int'(ch_r)*B_W +: B_W];
        c_sel_s = c_bat_r[int'(ch_r)*C_W +: C_W];
        issue_s = (state_r == ISSUE);
        conv_s  = OUT_W'(out_conv(SUM_MAX'(p_s), OUT_W));
    end

    mac_share_dsp #(
        .A_W   (A_W),
        .B_W   (B_W),
        .C_W   (C_W),
        .S_W   (S_W),
        .IDX_W (CNT_W)
    ) u_dsp (
        .clk      (ap_clk),
        .rst_n    (ap_rst_n),
        .ce       (ap_ce),
        .in_valid (issue_s),
        .in_idx   (ch_r),
        .a        (a_sel_s),
        .b        (b_sel_s),
        .c        (c_sel_s),
        .p        (p_s),
        .p_valid  (p_valid_s),
        .p_idx    (p_idx_s)
    );

    // Batch sequencer: capture, issue one channel per cycle, drain, hold.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_r     <= IDLE;
            ch_r        <= '0;
            a_bat_r     <= '0;
            b_bat_r     <= '0;
            c_bat_r     <= '0;
            out_valid_r <= 1'b0;
        end else if (ap_ce) begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_bat_r <= a;
                        b_bat_r <= b;
                        c_bat_r <= c;
                        ch_r    <= '0;
                        state_r <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (ch_r == LAST_CH) begin
                        ch_r    <= '0;
                        state_r <= DRAIN;
                    end else begin
                        ch_r <= ch_r + CNT_W'(1);
                    end
                end
                DRAIN: begin
                    // The last channel's slot is written on this same edge.
                    if (p_valid_s && (p_idx_s == LAST_CH)) begin
                        out_valid_r <= 1'b1;
                        state_r     <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    ch_r        <= '0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    // Result slot array, written as each tagged sum leaves the datapath.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            dout_r <= '0;
        end else if (ap_ce && p_valid_s) begin
            dout_r[int'(p_idx_s)*OUT_W +: OUT_W] <= conv_s;
        end
    end

    assign in_ready  = (state_r == IDLE) & ap_ce;
    assign out_valid = out_valid_r;
    assign dout      = dout_r;

endmodule
